// File: rtl/quad_encoder_emulator_if.sv
// Command channel for the quadrature encoder emulator.
// Master offers a motion command; slave accepts on valid && ready.
interface quad_encoder_emulator_if #(
  parameter int CNT_W = 24,
  parameter int PER_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [PER_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator with step count, direction and edge period.
// Optional index output quadZ is enabled by defining QUAD_EMU_INDEX_EN.
module quad_encoder_emulator #(
  parameter int CNT_W      = 24,
  parameter int PER_W      = 16,
  parameter int MIN_PERIOD = 8
`ifdef QUAD_EMU_INDEX_EN
  ,
  parameter int PPR        = 1024
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  quad_encoder_emulator_if.slave   cmd,
  input  logic                     abort,
  input  logic                     zero_cntrs,
  output logic                     quadA,
  output logic                     quadB,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         position
`ifdef QUAD_EMU_INDEX_EN
  ,
  output logic                     quadZ
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       phase_q, phase_d;
  logic [PER_W-1:0] timer_q, per_q, period_d;
  logic [CNT_W-1:0] rem_q, pos_q, pos_d;
  logic             dir_q, abort_q;
  logic             ready_q, busy_q, done_q;
  logic             step_en;

`ifdef QUAD_EMU_INDEX_EN
  localparam int IDX_W = (PPR > 1) ? $clog2(PPR) : 1;
  logic [IDX_W-1:0] idx_q, idx_d;
`endif

  assign step_en  = (state_q == RUN) && (timer_q == '0);
  assign period_d = (cmd.cmd_period < PER_W'(MIN_PERIOD))
                  ? PER_W'(MIN_PERIOD) : cmd.cmd_period;
  assign pos_d    = dir_q ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);

  // Next quadrature phase: A leads B going forward
  always_comb begin
    phase_d = phase_q;
    case ({dir_q, phase_q})
      3'b1_00: phase_d = 2'b10;
      3'b1_10: phase_d = 2'b11;
      3'b1_11: phase_d = 2'b01;
      3'b1_01: phase_d = 2'b00;
      3'b0_00: phase_d = 2'b01;
      3'b0_01: phase_d = 2'b11;
      3'b0_11: phase_d = 2'b10;
      3'b0_10: phase_d = 2'b00;
      default: phase_d = phase_q;
    endcase
  end

`ifdef QUAD_EMU_INDEX_EN
  // Index counter step, wrapping at 0 / PPR-1
  always_comb begin
    idx_d = idx_q;
    if (dir_q)
      idx_d = (idx_q == IDX_W'(PPR - 1)) ? '0 : idx_q + IDX_W'(1);
    else
      idx_d = (idx_q == '0) ? IDX_W'(PPR - 1) : idx_q - IDX_W'(1);
  end

  assign quadZ = (idx_q == '0) && (phase_q == 2'b00);
`endif

  // Motion FSM, edge timer, phase and position tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= 2'b00;
      timer_q <= '0;
      per_q   <= '0;
      rem_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      abort_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef QUAD_EMU_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd.cmd_valid) begin
            dir_q   <= cmd.cmd_dir;
            per_q   <= period_d;
            abort_q <= 1'b0;
            ready_q <= 1'b0;
            if (cmd.cmd_steps != '0) begin
              state_q <= RUN;
              timer_q <= period_d - PER_W'(1);
              rem_q   <= cmd.cmd_steps;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) abort_q <= 1'b1;
          if (timer_q != '0) begin
            timer_q <= timer_q - PER_W'(1);
          end else begin
            phase_q <= phase_d;
            rem_q   <= rem_q - CNT_W'(1);
            timer_q <= per_q - PER_W'(1);
            if (rem_q == CNT_W'(1) || abort || abort_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
      if (zero_cntrs) begin
        pos_q <= '0;
`ifdef QUAD_EMU_INDEX_EN
        idx_q <= '0;
`endif
      end else if (step_en) begin
        pos_q <= pos_d;
`ifdef QUAD_EMU_INDEX_EN
        idx_q <= idx_d;
`endif
      end
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign quadA         = phase_q[1];
  assign quadB         = phase_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign position      = pos_q;

endmodule

// File: doc/quad_encoder_emulator.md
Name: quad_encoder_emulator

Overview:
- Generates quadrature A/B waveforms that emulate a rotary encoder. Motion comes from a command: step count, direction and edge period.
- Drives the FPGAbot encoder counter inputs for bench/loopback self-test and motor-less bring-up.
- Every emitted edge equals exactly one count at the decoder.
- Tracks its own signed position so software can cross-check the decoder count.

Parameters:
CNT_W, 24, width of step count and position registers
PER_W, 16, width of edge-period field (clk cycles per quadrature edge)
MIN_PERIOD, 8, minimum allowed edge period; smaller requests are clamped (decoder uses 3-stage sync)
PPR, 1024, edges per revolution for index generation (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  emulator can accept command
cmd_steps  in  CNT_W  number of edges to emit (unsigned)
cmd_dir  in  1  1 = forward, 0 = reverse
cmd_period  in  PER_W  clk cycles between edges
abort  in  1  stop motion at the next edge boundary
zero_cntrs  in  1  clear position register
quadA  out  1  emulated channel A
quadB  out  1  emulated channel B
busy  out  1  motion in progress
done  out  1  one-cycle pulse when a command completes or aborts
position  out  CNT_W  signed running position (two's complement)

Behaviour:
- Reset (rst==0 at posedge clk) sets the following:
  - state=IDLE.
  - quadA=0, quadB=0, phase=00.
  - cmd_ready=1, busy=0, done=0.
  - position=0; timer and remaining counter cleared.
  - Reset mid-motion aborts immediately; no done pulse is issued.
- Handshake: a command is accepted on a posedge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE).
  - cmd_* are latched on acceptance and ignored afterwards.
- Period clamp: eff_period = max(cmd_period, MIN_PERIOD); latched at acceptance.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on acceptance with cmd_steps != 0. Sets timer=eff_period-1, remaining=cmd_steps, busy=1.
  - IDLE -> DONE on acceptance with cmd_steps == 0. No edges are emitted.
  - RUN, timer != 0: decrement timer.
  - RUN, timer == 0:
    - Advance phase one step and decrement remaining.
    - Update position +1 (fwd) or -1 (rev), with wrap-around modulo 2^CNT_W.
    - Reload timer.
    - If remaining becomes 0, or abort is sampled high on this cycle, go to DONE.
  - Abort sampled while timer != 0: finishes the current period, emits the pending edge, then goes to DONE. At most one further edge follows abort.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE. cmd_ready=1 the cycle after DONE.
- Phase sequence (quadA,quadB):
  - Forward: 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  - Reverse: the same sequence traversed backwards.
  - Exactly one output bit changes per edge.
- quadA/quadB are registered directly from the phase register; no glitches.
- First edge appears eff_period cycles after acceptance. Edge spacing is exactly eff_period cycles.
- Phase is retained between commands. A new command continues from the current phase with no spurious edge, including on a direction reversal.
- zero_cntrs clears position on the next clk.
  - It has priority over a same-cycle edge update.
  - It does not affect phase, motion or quadA/B.
- abort while IDLE is ignored.

Optional Feature:
- Macro QUAD_EMU_INDEX_EN.
- When defined:
  - Adds output quadZ (1 bit) and an internal index counter modulo PPR.
  - The counter increments on forward edges and decrements on reverse edges, wrapping at 0 / PPR-1.
  - quadZ=1 while the index counter == 0 and phase == 00; otherwise 0.
  - Reset: index counter=0, so quadZ=1.
  - zero_cntrs also clears the index counter.
- When undefined: no quadZ port and no index logic. Port list and behaviour are otherwise identical.

Test Plan:
- Reset, then command steps=4, dir=1, period=10 -> (A,B) goes 10,11,01,00 at cycles 10,20,30,40 after acceptance. done pulse follows, position=4, cmd_ready high again.
- Command steps=3, dir=0, period=2 -> period clamped to 8. Edges 8 cycles apart, phase 00->01->11->10, position=-3 (0xFFFFFD).
- Command steps=100, period=8, abort asserted at cycle 20 after accept -> exactly 3 edges, one done pulse, position=3, no further edges.
- Loopback into the encoder counter: fwd 1000 steps, then rev 250 steps -> decoder count=750 = position, pos_count=1250.
- steps=0 -> no edge, done pulse 1 cycle after acceptance. rst driven low mid-run -> outputs 0 next cycle, no done pulse.
- With QUAD_EMU_INDEX_EN, PPR=8: fwd 16 steps -> quadZ high exactly at edges 8 and 16 (phase 00). zero_cntrs during run -> position=0 next cycle, edges continue.
